// File: rtl/fifo_stat.sv
// Parametrised FWFT FIFO with occupancy count, almost-full/empty and sticky error flags.
// Define FIFO_STAT_PEAK_EN to track peak occupancy; otherwise peak is tied to 0.
module fifo_stat #(
  parameter int unsigned B        = 8,
  parameter int unsigned W        = 4,
  parameter int unsigned AF_LEVEL = (1 << W) - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [B-1:0] w_data,
  input  logic         clr_err,
  output logic [B-1:0] r_data,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow,
  output logic [W:0]   peak
);

  localparam int unsigned Depth    = 1 << W;
  localparam logic [W:0]  DepthCnt = {1'b1, {W{1'b0}}};
  localparam logic [W:0]  AfCnt    = (W+1)'(AF_LEVEL);
  localparam logic [W:0]  AeCnt    = (W+1)'(AE_LEVEL);
  localparam logic        AfRst    = (AF_LEVEL == 0);

  logic [B-1:0] mem_q [Depth];

  logic [W-1:0] w_ptr_q, w_ptr_d;
  logic [W-1:0] r_ptr_q, r_ptr_d;
  logic [W:0]   count_q, count_d;
  logic         full_q, full_d;
  logic         empty_q, empty_d;
  logic         af_q, af_d;
  logic         ae_q, ae_d;
  logic         ovf_q, ovf_d;
  logic         udf_q, udf_d;
  logic         wr_ok, rd_ok;

  // A write into a full FIFO is still accepted when a read frees the head slot.
  assign rd_ok = rd & ~empty_q;
  assign wr_ok = wr & (~full_q | rd_ok);

  always_comb begin
    w_ptr_d = wr_ok ? w_ptr_q + W'(1) : w_ptr_q;
    r_ptr_d = rd_ok ? r_ptr_q + W'(1) : r_ptr_q;
    count_d = count_q + (W+1)'(wr_ok) - (W+1)'(rd_ok);
    full_d  = (count_d == DepthCnt);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AfCnt);
    ae_d    = (count_d <= AeCnt);
    // Clear wins over a same-cycle set.
    ovf_d   = clr_err ? 1'b0 : (ovf_q | (wr & ~wr_ok));
    udf_d   = clr_err ? 1'b0 : (udf_q | (rd & ~rd_ok & ~wr));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= AfRst;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[w_ptr_q] <= w_data;
    end
  end

  assign r_data       = mem_q[r_ptr_q];
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

`ifdef FIFO_STAT_PEAK_EN
  logic [W:0] peak_q, peak_d;

  // Clear restarts tracking from the post-edge occupancy rather than zero.
  always_comb begin
    if (clr_err) begin
      peak_d = count_d;
    end else begin
      peak_d = (count_d > peak_q) ? count_d : peak_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_fifo_stat.sv
// Scoreboard bench for fifo_stat (B=3, W=2): directed steps push expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_fifo_stat;

  logic       clk;
  logic       reset;
  logic       wr;
  logic       rd;
  logic       clr_err;
  logic [2:0] w_data;
  logic [2:0] r_data;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;
  logic [2:0] peak;

  fifo_stat #(
    .B(3),
    .W(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .rd          (rd),
    .w_data      (w_data),
    .clr_err     (clr_err),
    .r_data      (r_data),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .peak        (peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] cnt;
    logic [2:0] head;
    logic       ov;
    logic       un;
    logic [2:0] pk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Flag expectations follow directly from the expected count (AF_LEVEL=3, AE_LEVEL=1).
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.name, " count"}, count, mon_e.cnt);
      check({mon_e.name, " full"}, {2'b0, full}, {2'b0, mon_e.cnt == 3'd4});
      check({mon_e.name, " empty"}, {2'b0, empty}, {2'b0, mon_e.cnt == 3'd0});
      check({mon_e.name, " almost_full"}, {2'b0, almost_full}, {2'b0, mon_e.cnt >= 3'd3});
      check({mon_e.name, " almost_empty"}, {2'b0, almost_empty}, {2'b0, mon_e.cnt <= 3'd1});
      check({mon_e.name, " overflow"}, {2'b0, overflow}, {2'b0, mon_e.ov});
      check({mon_e.name, " underflow"}, {2'b0, underflow}, {2'b0, mon_e.un});
      if (mon_e.cnt != 3'd0) check({mon_e.name, " r_data"}, r_data, mon_e.head);
`ifdef FIFO_STAT_PEAK_EN
      check({mon_e.name, " peak"}, peak, mon_e.pk);
`else
      check({mon_e.name, " peak"}, peak, 3'd0);
`endif
    end
  end

  task automatic expect_state(input string name, input logic [2:0] cnt, input logic [2:0] head,
                              input logic ov, input logic un, input logic [2:0] pk);
    exp_t e;
    e.name = name;
    e.cnt  = cnt;
    e.head = head;
    e.ov   = ov;
    e.un   = un;
    e.pk   = pk;
    exp_q.push_back(e);
  endtask

  task automatic step(input string name, input logic w, input logic r, input logic c,
                      input logic [2:0] d, input logic [2:0] cnt, input logic [2:0] head,
                      input logic ov, input logic un, input logic [2:0] pk);
    wr      = w;
    rd      = r;
    clr_err = c;
    w_data  = d;
    @(posedge clk);
    #1;
    wr      = 1'b0;
    rd      = 1'b0;
    clr_err = 1'b0;
    expect_state(name, cnt, head, ov, un, pk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    wr      = 1'b0;
    rd      = 1'b0;
    clr_err = 1'b0;
    w_data  = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    expect_state("reset", 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);

    //   name          wr    rd    clr   data  cnt   head  ov    un    pk
    step("fill1",      1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0, 3'd1);
    step("fill2",      1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 3'd1, 1'b0, 1'b0, 3'd2);
    step("fill3",      1'b1, 1'b0, 1'b0, 3'd3, 3'd3, 3'd1, 1'b0, 1'b0, 3'd3);
    step("fill4",      1'b1, 1'b0, 1'b0, 3'd4, 3'd4, 3'd1, 1'b0, 1'b0, 3'd4);
    step("ovf_wr",     1'b1, 1'b0, 1'b0, 3'd7, 3'd4, 3'd1, 1'b1, 1'b0, 3'd4);
    step("drain1",     1'b0, 1'b1, 1'b0, 3'd0, 3'd3, 3'd2, 1'b1, 1'b0, 3'd4);
    step("drain2",     1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 3'd3, 1'b1, 1'b0, 3'd4);
    step("drain3",     1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 3'd4, 1'b1, 1'b0, 3'd4);
    step("drain4",     1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd4);
    step("wrap_w1",    1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 3'd1, 1'b1, 1'b0, 3'd4);
    step("wrap_r1",    1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd4);
    step("wrap_w2",    1'b1, 1'b0, 1'b0, 3'd2, 3'd1, 3'd2, 1'b1, 1'b0, 3'd4);
    step("wrap_r2",    1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd4);
    step("clr_ovf",    1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    step("udf_rd",     1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd0);
    step("clr_udf",    1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    step("rd_clr",     1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    step("empty_wr",   1'b1, 1'b1, 1'b0, 3'd5, 3'd1, 3'd5, 1'b0, 1'b0, 3'd1);
    step("refill1",    1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 3'd5, 1'b0, 1'b0, 3'd2);
    step("refill2",    1'b1, 1'b0, 1'b0, 3'd2, 3'd3, 3'd5, 1'b0, 1'b0, 3'd3);
    step("refill3",    1'b1, 1'b0, 1'b0, 3'd3, 3'd4, 3'd5, 1'b0, 1'b0, 3'd4);
    step("full_wr",    1'b1, 1'b1, 1'b0, 3'd6, 3'd4, 3'd1, 1'b0, 1'b0, 3'd4);
    step("pop_a",      1'b0, 1'b1, 1'b0, 3'd0, 3'd3, 3'd2, 1'b0, 1'b0, 3'd4);
    step("pop_b",      1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 3'd3, 1'b0, 1'b0, 3'd4);
    step("pop_c",      1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 3'd6, 1'b0, 1'b0, 3'd4);
    step("pop_d",      1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd4);
    step("burst1",     1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0, 3'd4);
    step("burst2",     1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 3'd1, 1'b0, 1'b0, 3'd4);

    // Reset pulse strictly between edges, with the third write pending on the bus.
    @(negedge clk);
    #1;
    wr     = 1'b1;
    w_data = 3'd3;
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    wr = 1'b0;
    expect_state("rst_mid", 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    #1;

    step("post_rst",   1'b1, 1'b0, 1'b0, 3'd2, 3'd1, 3'd2, 1'b0, 1'b0, 3'd1);
    step("pk_rd0",     1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd1);
    step("pk_clr0",    1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    step("pk_w1",      1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0, 3'd1);
    step("pk_w2",      1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 3'd1, 1'b0, 1'b0, 3'd2);
    step("pk_w3",      1'b1, 1'b0, 1'b0, 3'd3, 3'd3, 3'd1, 1'b0, 1'b0, 3'd3);
    step("pk_r1",      1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 3'd2, 1'b0, 1'b0, 3'd3);
    step("pk_r2",      1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 3'd3, 1'b0, 1'b0, 3'd3);
    step("pk_clr1",    1'b0, 1'b0, 1'b1, 3'd0, 3'd1, 3'd3, 1'b0, 1'b0, 3'd1);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
